// File: rtl/imem_responder_if.sv
// Fetch and programming signals between the fetch stage / UART receiver and the instruction memory.
// Master drives the fetch request and the programming byte stream.
// Slave returns fetch data and programming status.
interface imem_responder_if #(
  parameter int ADDR_W = 12
);
  logic              imem_en;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_dout;
  logic              prog_start;
  logic              prog_valid;
  logic [7:0]        prog_byte;
  logic              prog_end;
  logic              memcon_prog_ena;
  logic [ADDR_W:0]   prog_word_count;
  logic              prog_overflow;

  modport master (
    output imem_en, imem_addr, prog_start, prog_valid, prog_byte, prog_end,
    input  imem_dout, memcon_prog_ena, prog_word_count, prog_overflow
  );

  modport slave (
    input  imem_en, imem_addr, prog_start, prog_valid, prog_byte, prog_end,
    output imem_dout, memcon_prog_ena, prog_word_count, prog_overflow
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with halfword-aligned fetch and a UART byte-stream loader.
// Latency: fetch data 1 cycle after imem_en; loader writes one word per cycle at most.
// Backpressure: none; imem_en=0 holds imem_dout, fetch is held in reset while loading.
module imem_responder #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic            clk,
  input  logic            Rst,
  imem_responder_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int HALF   = DEPTH_WORDS / 2;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;        // bytes of lanes 0..2 awaiting lane 3
  logic [ADDR_W:0]   ptr_q, ptr_d;        // write pointer, doubles as word count
  logic              ovf_q, ovf_d;
  logic              rd_vld_q, rd_vld_d;  // low forces imem_dout to 0
  logic              half_q, half_d;      // captured imem_addr[1]
  logic              odd_first_q, odd_first_d; // low word came from the odd bank

  logic [31:0]       even_mem [HALF];
  logic [31:0]       odd_mem  [HALF];
  logic [31:0]       even_rd_q, odd_rd_q;

  logic              full;
  logic              wr_en;
  logic [31:0]       wr_dat;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_w, rd_w1;
  logic [ADDR_W-2:0] even_idx, odd_idx;
  logic [31:0]       lo, hi;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.imem_addr[31:ADDR_W+2], bus.imem_addr[0]};

  // Read addressing: word w and w+1 always land in opposite banks, so both are read together.
  always_comb begin
    rd_en       = (state_q == S_IDLE) && bus.imem_en;
    rd_w        = bus.imem_addr[ADDR_W+1:2];
    rd_w1       = rd_w + 1'b1;
    odd_idx     = rd_w[ADDR_W-1:1];
    even_idx    = rd_w[0] ? rd_w1[ADDR_W-1:1] : rd_w[ADDR_W-1:1];
    half_d      = rd_en ? bus.imem_addr[1] : half_q;
    odd_first_d = rd_en ? rd_w[0] : odd_first_q;
  end

  // Loader FSM: assembles bytes little-endian, writes full words, flushes a partial word on end.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    rd_vld_d = rd_vld_q;
    wr_en    = 1'b0;
    wr_dat   = 32'h0;
    full     = (ptr_q == FULL);
    case (state_q)
      S_IDLE: begin
        if (bus.prog_start) begin
          state_d  = S_LOAD;
          lane_d   = 2'd0;
          asm_d    = 24'h0;
          ptr_d    = '0;
          ovf_d    = 1'b0;
          rd_vld_d = 1'b0;
        end else if (bus.imem_en) begin
          rd_vld_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.prog_valid) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (lane_q == 2'd3) begin
            wr_en  = 1'b1;
            wr_dat = {bus.prog_byte, asm_q};
            ptr_d  = ptr_q + 1'b1;
            lane_d = 2'd0;
            asm_d  = 24'h0;
          end else begin
            asm_d[{lane_q, 3'b000} +: 8] = bus.prog_byte;
            lane_d = lane_q + 2'd1;
          end
        end
        if (bus.prog_end) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (lane_q != 2'd0) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_dat = {8'h00, asm_q};
            ptr_d  = ptr_q + 1'b1;
          end
        end
        lane_d  = 2'd0;
        asm_d   = 24'h0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Even bank: loader write port plus registered fetch read port (contents survive Rst).
  always_ff @(posedge clk) begin
    if (wr_en && !ptr_q[0]) even_mem[ptr_q[ADDR_W-1:1]] <= wr_dat;
    if (rd_en) even_rd_q <= even_mem[even_idx];
  end

  // Odd bank: same structure as the even bank.
  always_ff @(posedge clk) begin
    if (wr_en && ptr_q[0]) odd_mem[ptr_q[ADDR_W-1:1]] <= wr_dat;
    if (rd_en) odd_rd_q <= odd_mem[odd_idx];
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'd0;
      asm_q       <= 24'h0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      half_q      <= 1'b0;
      odd_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      ptr_q       <= ptr_d;
      ovf_q       <= ovf_d;
      rd_vld_q    <= rd_vld_d;
      half_q      <= half_d;
      odd_first_q <= odd_first_d;
    end
  end

  // Output: reorder banks into lo/hi words, then pick the aligned or straddling word.
  always_comb begin
    lo = odd_first_q ? odd_rd_q : even_rd_q;
    hi = odd_first_q ? even_rd_q : odd_rd_q;
    bus.imem_dout       = !rd_vld_q ? 32'h0 : (half_q ? {hi[15:0], lo[31:16]} : lo);
    bus.memcon_prog_ena = (state_q != S_IDLE);
    bus.prog_word_count = ptr_q;
    bus.prog_overflow   = ovf_q;
  end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder with a 16-word memory.
// Table-driven fetch vectors plus hand sequences for sessions, hold, wrap, overflow and reset.
// Read expectations go through a queue at drive time and are popped when data is due.
module tb_imem_responder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if #(.ADDR_W(AW)) bus ();
  imem_responder #(.DEPTH_WORDS(DEPTH)) dut (.clk(clk), .Rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  bq [$];
  logic [31:0] model [DEPTH];
  logic [31:0] words [DEPTH];
  vec_t        tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    logic [31:0] lo, hi;
    w  = int'(a[AW+1:2]);
    lo = model[w];
    hi = model[(w + 1) % DEPTH];
    return a[1] ? {hi[15:0], lo[31:16]} : lo;
  endfunction

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus.imem_en   = 1'b1;
    bus.imem_addr = a;
    exp_q.push_back(exp);
    tick();
    bus.imem_en = 1'b0;
    chk(nm, bus.imem_dout, exp_q.pop_front());
  endtask

  task automatic words_to_bytes(input int n);
    bq.delete();
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++) bq.push_back(words[w][8*b +: 8]);
  endtask

  // Runs a complete session over bq; prog_end rides on the last byte or follows alone.
  task automatic session(input bit end_with_last);
    int nb;
    nb = bq.size();
    bus.prog_start = 1'b1;
    tick();
    bus.prog_start = 1'b0;
    chk("ena_load", 32'(bus.memcon_prog_ena), 32'd1);
    chk("count_clr", 32'(bus.prog_word_count), 32'd0);
    chk("dout_load", bus.imem_dout, 32'h0);
    for (int i = 0; i < nb; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_byte  = bq[i];
      bus.prog_end   = end_with_last && (i == nb - 1);
      if (i / 4 < DEPTH) begin
        if (i % 4 == 0) model[i/4] = 32'h0;
        model[i/4][8*(i%4) +: 8] = bq[i];
      end
      tick();
      chk("ena_bytes", 32'(bus.memcon_prog_ena), 32'd1);
    end
    bus.prog_valid = 1'b0;
    bus.prog_end   = 1'b0;
    if (!end_with_last) begin
      bus.prog_end = 1'b1;
      tick();
      bus.prog_end = 1'b0;
      chk("ena_flush", 32'(bus.memcon_prog_ena), 32'd1);
    end
    tick();
    chk("ena_idle", 32'(bus.memcon_prog_ena), 32'd0);
  endtask

  initial begin
    bus.imem_en    = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.prog_start = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_byte  = 8'h0;
    bus.prog_end   = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_dout", bus.imem_dout, 32'h0);
    chk("rst_ena", 32'(bus.memcon_prog_ena), 32'd0);
    chk("rst_count", 32'(bus.prog_word_count), 32'd0);
    chk("rst_ovf", 32'(bus.prog_overflow), 32'd0);

    // Bytes offered while idle must not enter the assembly register.
    bus.prog_valid = 1'b1;
    bus.prog_byte  = 8'hFF;
    tick();
    bus.prog_valid = 1'b0;

    // Basic session.
    bq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    session(1'b0);
    chk("s1_count", 32'(bus.prog_word_count), 32'd2);
    chk("s1_dout_idle", bus.imem_dout, 32'h0);
    rd(32'd0, 32'h00500013, "s1_w0");
    rd(32'd4, 32'h00100093, "s1_w1");

    // Fill memory exactly; straddle and alias vectors.
    for (int i = 0; i < DEPTH; i++) words[i] = 32'h5A000000 | 32'(i);
    words[0]  = 32'hAAAA4501;
    words[1]  = 32'h00B3BBBB;
    words[2]  = 32'hCAFE1234;
    words[15] = 32'h12345678;
    words_to_bytes(DEPTH);
    session(1'b0);
    chk("s2_count", 32'(bus.prog_word_count), 32'd16);
    chk("s2_ovf", 32'(bus.prog_overflow), 32'd0);
    tbl[0] = '{addr: 32'd0,  exp: 32'hAAAA4501, nm: "s2_a0"};
    tbl[1] = '{addr: 32'd2,  exp: 32'hBBBBAAAA, nm: "s2_straddle2"};
    tbl[2] = '{addr: 32'd3,  exp: 32'hBBBBAAAA, nm: "s2_bit0_ignored"};
    tbl[3] = '{addr: 32'd4,  exp: 32'h00B3BBBB, nm: "s2_a4"};
    tbl[4] = '{addr: 32'd6,  exp: 32'h123400B3, nm: "s2_straddle6"};
    tbl[5] = '{addr: 32'd62, exp: 32'h45011234, nm: "s2_wrap"};
    tbl[6] = '{addr: 32'd66, exp: 32'hBBBBAAAA, nm: "s2_alias"};
    tbl[7] = '{addr: 32'd8,  exp: 32'hCAFE1234, nm: "s2_a8"};
    for (int i = 0; i < 8; i++) rd(tbl[i].addr, tbl[i].exp, tbl[i].nm);
    for (int a = 0; a < 4 * DEPTH; a += 2) rd(32'(a), model_read(32'(a)), "s2_sweep");

    // Hold with imem_en low, then re-enable.
    rd(32'd0, 32'hAAAA4501, "hold_first");
    for (int a = 4; a <= 32'h40; a += 4) begin
      bus.imem_addr = 32'(a);
      tick();
      chk("hold", bus.imem_dout, 32'hAAAA4501);
    end
    rd(32'd4, 32'h00B3BBBB, "hold_reen");

    // Partial word flushed, prog_end with the last byte.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hCC, 8'hDD};
    session(1'b1);
    chk("s5_count", 32'(bus.prog_word_count), 32'd2);
    rd(32'd4, 32'h0000DDCC, "s5_partial");
    rd(32'd0, 32'h44332211, "s5_w0");
    rd(32'd2, 32'hDDCC4433, "s5_straddle");
    rd(32'd6, model_read(32'd6), "s5_a6");

    // Overflow: one byte past a full memory, then wrap read.
    for (int i = 0; i < DEPTH; i++) words[i] = 32'h11111111 * 32'(i);
    words[0]  = 32'h9ABCDEF0;
    words[15] = 32'h12345678;
    words_to_bytes(DEPTH);
    bq.push_back(8'hEE);
    session(1'b0);
    chk("ovf_flag", 32'(bus.prog_overflow), 32'd1);
    chk("ovf_count", 32'(bus.prog_word_count), 32'd16);
    rd(32'd62, 32'hDEF01234, "ovf_wrap");
    rd(32'd0, 32'h9ABCDEF0, "ovf_w0");

    // New session interrupted by reset after two bytes.
    bus.prog_start = 1'b1;
    tick();
    bus.prog_start = 1'b0;
    chk("rs_ena", 32'(bus.memcon_prog_ena), 32'd1);
    chk("rs_ovf_clr", 32'(bus.prog_overflow), 32'd0);
    for (int i = 0; i < 2; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_byte  = 8'h77;
      tick();
    end
    bus.prog_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_ena_off", 32'(bus.memcon_prog_ena), 32'd0);
    chk("rs_count", 32'(bus.prog_word_count), 32'd0);
    chk("rs_dout", bus.imem_dout, 32'h0);
    tick();
    rd(32'd0, 32'h9ABCDEF0, "rs_w0_kept");
    rd(32'd4, 32'h11111111, "rs_w1_kept");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
